// File: rtl/cci_mpf_app_mux.sv
// cci_mpf_app_mux: N-way request mux with per-app FIFOs, round-robin issue and tag-routed responses.
module cci_mpf_app_mux #(
    parameter int NUM_APPS      = 4,
    parameter int REQ_W         = 64,
    parameter int RSP_W         = 512,
    parameter int MDATA_W       = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int ALMFULL_SLACK = 3,
    parameter int MAX_OUTST     = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_APPS-1:0]         app_req_valid,
    input  logic [NUM_APPS*REQ_W-1:0]   app_req_data,
    input  logic [NUM_APPS*MDATA_W-1:0] app_req_mdata,
    output logic [NUM_APPS-1:0]         app_almFull,
    output logic [NUM_APPS-1:0]         app_rsp_valid,
    output logic [RSP_W-1:0]            app_rsp_data,
    output logic [MDATA_W-1:0]          app_rsp_mdata,
    output logic [NUM_APPS-1:0]         app_notEmpty,
    output logic                        fiu_req_valid,
    output logic [REQ_W-1:0]            fiu_req_data,
    output logic [MDATA_W-1:0]          fiu_req_mdata,
    input  logic                        fiu_almFull,
    input  logic                        fiu_rsp_valid,
    input  logic [RSP_W-1:0]            fiu_rsp_data,
    input  logic [MDATA_W-1:0]          fiu_rsp_mdata,
    output logic                        tag_err
);
    localparam int TAG_W = $clog2(NUM_APPS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int OW    = $clog2(MAX_OUTST + 1);
    localparam int EW    = REQ_W + MDATA_W;

    logic [EW-1:0]       head [NUM_APPS];
    logic [NUM_APPS-1:0] elig, pop, rsp_hit;
    logic [TAG_W-1:0]    rr, gnt, rsp_tag;
    logic                gnt_vld, tag_ok;
    int                  idx;

    assign rsp_tag = fiu_rsp_mdata[MDATA_W-1 -: TAG_W];
    assign tag_ok  = int'(rsp_tag) < NUM_APPS;
    assign pop     = {NUM_APPS{gnt_vld}} & (NUM_APPS'(1) << gnt);
    assign rsp_hit = {NUM_APPS{fiu_rsp_valid && tag_ok}} & (NUM_APPS'(1) << rsp_tag);

    // Scan downward so the candidate closest to the pointer is the one left standing.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = NUM_APPS - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= NUM_APPS) idx = idx - NUM_APPS;
            if (elig[idx] && !fiu_almFull) begin
                gnt_vld = 1'b1;
                gnt     = TAG_W'(idx);
            end
        end
    end

    for (genvar i = 0; i < NUM_APPS; i++) begin : g_app
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] wp, rp;
        logic [CW-1:0] cnt, cnt_nxt;
        logic [OW-1:0] outst;
        logic          push, af;
        assign push            = app_req_valid[i] && cnt != CW'(FIFO_DEPTH);
        assign cnt_nxt         = cnt + CW'(push) - CW'(pop[i]);
        assign head[i]         = mem[rp];
        assign elig[i]         = cnt != '0 && outst != OW'(MAX_OUTST);
        assign app_notEmpty[i] = cnt != '0 || outst != '0;
        assign app_almFull[i]  = af;
        always_ff @(posedge clk) begin
            if (push) mem[wp] <= {app_req_data[i*REQ_W +: REQ_W], app_req_mdata[i*MDATA_W +: MDATA_W]};
            if (reset) begin
                wp    <= '0;
                rp    <= '0;
                cnt   <= '0;
                outst <= '0;
                af    <= 1'b0;
            end else begin
                assert (!(app_req_valid[i] && cnt == CW'(FIFO_DEPTH)))
                    else $error("app %0d request FIFO overflow, entry dropped", i);
                assert (!(rsp_hit[i] && outst == '0))
                    else $error("app %0d response with no outstanding request", i);
                if (push) wp <= wp + AW'(1);
                if (pop[i]) rp <= rp + AW'(1);
                cnt <= cnt_nxt;
                af  <= cnt_nxt >= CW'(FIFO_DEPTH - ALMFULL_SLACK);
                if (pop[i] && !rsp_hit[i]) outst <= outst + OW'(1);
                else if (rsp_hit[i] && !pop[i] && outst != '0) outst <= outst - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr            <= '0;
            fiu_req_valid <= 1'b0;
            fiu_req_data  <= '0;
            fiu_req_mdata <= '0;
            app_rsp_valid <= '0;
            app_rsp_data  <= '0;
            app_rsp_mdata <= '0;
            tag_err       <= 1'b0;
        end else begin
            fiu_req_valid <= gnt_vld;
            if (gnt_vld) begin
                rr            <= (int'(gnt) == NUM_APPS - 1) ? '0 : gnt + TAG_W'(1);
                fiu_req_data  <= head[gnt][EW-1 -: REQ_W];
                fiu_req_mdata <= {gnt, head[gnt][MDATA_W-TAG_W-1:0]};
            end
            app_rsp_valid <= rsp_hit;
            app_rsp_data  <= fiu_rsp_data;
            app_rsp_mdata <= {TAG_W'(0), fiu_rsp_mdata[MDATA_W-TAG_W-1:0]};
            tag_err       <= tag_err || (fiu_rsp_valid && !tag_ok);
        end
    end
endmodule

// File: tb/tb_cci_mpf_app_mux.sv
// tb_cci_mpf_app_mux: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_cci_mpf_app_mux;
    localparam int N = 4, RW = 64, SW = 512, MW = 16, N3 = 3;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    app_req_valid, app_almFull, app_rsp_valid, app_notEmpty;
    logic [N*RW-1:0] app_req_data;
    logic [N*MW-1:0] app_req_mdata;
    logic [SW-1:0]   app_rsp_data, fiu_rsp_data;
    logic [MW-1:0]   app_rsp_mdata, fiu_req_mdata, fiu_rsp_mdata;
    logic [RW-1:0]   fiu_req_data;
    logic            fiu_req_valid, fiu_almFull, fiu_rsp_valid, tag_err;

    logic [N3-1:0]    d3_req_valid, d3_almfull, d3_rsp_valid, d3_not_empty;
    logic [N3*RW-1:0] d3_req_data;
    logic [N3*MW-1:0] d3_req_mdata;
    logic [SW-1:0]    d3_rsp_data_o, d3_rsp_data_i;
    logic [MW-1:0]    d3_rsp_mdata_o, d3_req_mdata_o, d3_rsp_mdata_i;
    logic [RW-1:0]    d3_req_data_o;
    logic             d3_req_valid_o, d3_fiu_almfull, d3_fiu_rsp_valid, d3_tag_err;

    cci_mpf_app_mux #(.NUM_APPS(N)) dut (
        .clk(clk), .reset(reset),
        .app_req_valid(app_req_valid), .app_req_data(app_req_data), .app_req_mdata(app_req_mdata),
        .app_almFull(app_almFull), .app_rsp_valid(app_rsp_valid), .app_rsp_data(app_rsp_data),
        .app_rsp_mdata(app_rsp_mdata), .app_notEmpty(app_notEmpty),
        .fiu_req_valid(fiu_req_valid), .fiu_req_data(fiu_req_data), .fiu_req_mdata(fiu_req_mdata),
        .fiu_almFull(fiu_almFull), .fiu_rsp_valid(fiu_rsp_valid), .fiu_rsp_data(fiu_rsp_data),
        .fiu_rsp_mdata(fiu_rsp_mdata), .tag_err(tag_err));

    cci_mpf_app_mux #(.NUM_APPS(N3)) dut3 (
        .clk(clk), .reset(reset),
        .app_req_valid(d3_req_valid), .app_req_data(d3_req_data), .app_req_mdata(d3_req_mdata),
        .app_almFull(d3_almfull), .app_rsp_valid(d3_rsp_valid), .app_rsp_data(d3_rsp_data_o),
        .app_rsp_mdata(d3_rsp_mdata_o), .app_notEmpty(d3_not_empty),
        .fiu_req_valid(d3_req_valid_o), .fiu_req_data(d3_req_data_o), .fiu_req_mdata(d3_req_mdata_o),
        .fiu_almFull(d3_fiu_almfull), .fiu_rsp_valid(d3_fiu_rsp_valid), .fiu_rsp_data(d3_rsp_data_i),
        .fiu_rsp_mdata(d3_rsp_mdata_i), .tag_err(d3_tag_err));

    int checks = 0, errors = 0;
    logic [RW+MW-1:0] mq [N][$];
    int               out_tags[$];
    logic [RW-1:0]    qd [5];
    logic [MW-1:0]    qm [5];

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One cycle of random traffic; every issue is matched against the front of that app's queue.
    task automatic rnd_cycle(input bit pushes, input bit rand_almfull);
        logic [N-1:0]  exp_rsp;
        logic [MW-1:0] exp_md;
        logic [RW-1:0] d;
        logic [MW-1:0] m;
        logic [13:0]   low;
        int            t, k;
        fiu_almFull = rand_almfull && ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N; i++) begin
            if (pushes && !app_almFull[i] && $urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                m = MW'($urandom);
                app_req_valid[i] = 1'b1;
                app_req_data[i*RW +: RW] = d;
                app_req_mdata[i*MW +: MW] = m;
                mq[i].push_back({d, m});
            end
        end
        exp_rsp = '0;
        exp_md  = '0;
        if (out_tags.size() > 0 && (!pushes || $urandom_range(0, 1) == 1)) begin
            k = $urandom_range(0, out_tags.size() - 1);
            t = out_tags[k];
            out_tags.delete(k);
            low = 14'($urandom);
            fiu_rsp_valid = 1'b1;
            fiu_rsp_mdata = {2'(t), low};
            exp_rsp = N'(1) << t;
            exp_md  = {2'b00, low};
        end
        tick();
        app_req_valid = '0;
        fiu_rsp_valid = 1'b0;
        chk("rnd_rsp_valid", app_rsp_valid, exp_rsp);
        if (exp_rsp != '0) chk("rnd_rsp_mdata", app_rsp_mdata, exp_md);
        if (fiu_req_valid) begin
            t = int'(fiu_req_mdata[MW-1 -: 2]);
            if (mq[t].size() == 0) chk("rnd_spurious_issue", 1, 0);
            else begin
                {d, m} = mq[t].pop_front();
                chk("rnd_req_data", fiu_req_data, d);
                chk("rnd_req_mdata", fiu_req_mdata, {2'(t), m[13:0]});
                out_tags.push_back(t);
            end
        end
    endtask

    initial begin
        int pending;
        app_req_valid = '0; app_req_data = '0; app_req_mdata = '0;
        fiu_almFull = 1'b0; fiu_rsp_valid = 1'b0; fiu_rsp_data = '0; fiu_rsp_mdata = '0;
        d3_req_valid = '0; d3_req_data = '0; d3_req_mdata = '0;
        d3_fiu_almfull = 1'b0; d3_fiu_rsp_valid = 1'b0; d3_rsp_data_i = '0; d3_rsp_mdata_i = '0;
        tick();
        tick();
        chk("rst_req_valid", fiu_req_valid, 0);
        chk("rst_almfull", app_almFull, 0);
        chk("rst_not_empty", app_notEmpty, 0);
        chk("rst_rsp_valid", app_rsp_valid, 0);
        chk("rst_tag_err", tag_err, 0);
        reset = 1'b0;

        // Three-app instance: tag 3 has no owner
        d3_fiu_rsp_valid = 1'b1;
        d3_rsp_mdata_i = 16'hC001;
        tick();
        d3_fiu_rsp_valid = 1'b0;
        chk("t5_rsp_valid", d3_rsp_valid, 0);
        chk("t5_tag_err", d3_tag_err, 1);
        tick();
        tick();
        chk("t5_tag_err_sticky", d3_tag_err, 1);
        chk("t5_main_tag_err", tag_err, 0);
        do_reset();
        chk("t5_tag_err_cleared", d3_tag_err, 0);

        // Single request from app0
        app_req_valid = 4'b0001;
        app_req_data[RW-1:0] = 64'hDEAD_BEEF_0000_0001;
        app_req_mdata[MW-1:0] = 16'h0123;
        tick();
        app_req_valid = '0;
        chk("t1_no_issue_yet", fiu_req_valid, 0);
        chk("t1_not_empty_q", app_notEmpty, 4'b0001);
        tick();
        chk("t1_issue", fiu_req_valid, 1);
        chk("t1_mdata", fiu_req_mdata, 16'h0123);
        chk("t1_data", fiu_req_data, 64'hDEAD_BEEF_0000_0001);
        tick();
        chk("t1_single", fiu_req_valid, 0);
        chk("t1_not_empty_outst", app_notEmpty, 4'b0001);
        fiu_rsp_valid = 1'b1;
        fiu_rsp_mdata = 16'h0123;
        fiu_rsp_data = {16{32'h1234_5678}};
        tick();
        fiu_rsp_valid = 1'b0;
        chk("t1_rsp_valid", app_rsp_valid, 4'b0001);
        chk("t1_rsp_mdata", app_rsp_mdata, 16'h0123);
        chk("t1_rsp_data", app_rsp_data, {16{32'h1234_5678}});
        chk("t1_not_empty_done", app_notEmpty, 0);
        do_reset();

        // All four apps at once: issued in index order
        app_req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            app_req_data[i*RW +: RW] = 64'hA5A5_0000_0000_0000 | 64'(i);
            app_req_mdata[i*MW +: MW] = 16'hFFF0 | 16'(i);
        end
        tick();
        app_req_valid = '0;
        tick();
        for (int k = 0; k < N; k++) begin
            chk("t2_issue", fiu_req_valid, 1);
            chk("t2_mdata", fiu_req_mdata, 16'((k << 14) | 16'h3FF0 | k));
            chk("t2_data", fiu_req_data, 64'hA5A5_0000_0000_0000 | 64'(k));
            tick();
        end
        chk("t2_done", fiu_req_valid, 0);
        for (int t = 0; t < 3; t++) begin
            fiu_rsp_valid = 1'b1;
            fiu_rsp_mdata = 16'(t << 14);
            tick();
            chk("t2_rsp_route", app_rsp_valid, 4'(1 << t));
        end
        fiu_rsp_valid = 1'b0;
        tick();
        chk("t2_outst_app3", app_notEmpty, 4'b1000);

        // Issue and response for app3 at the same time
        app_req_valid = 4'b1000;
        app_req_mdata[3*MW +: MW] = 16'h0ABC;
        tick();
        app_req_valid = '0;
        fiu_rsp_valid = 1'b1;
        fiu_rsp_mdata = 16'hC055;
        tick();
        fiu_rsp_valid = 1'b0;
        chk("t4_rsp_valid", app_rsp_valid, 4'b1000);
        chk("t4_rsp_mdata", app_rsp_mdata, 16'h0055);
        chk("t4_issue_mdata", fiu_req_mdata, 16'hCABC);
        tick();
        chk("t4_counter_held", app_notEmpty, 4'b1000);
        fiu_rsp_valid = 1'b1;
        fiu_rsp_mdata = 16'hC000;
        tick();
        fiu_rsp_valid = 1'b0;
        tick();
        chk("t4_counter_zero", app_notEmpty, 0);

        // Backpressure while app2 fills
        fiu_almFull = 1'b1;
        for (int p = 0; p < 5; p++) begin
            qd[p] = {$urandom, $urandom};
            qm[p] = MW'($urandom);
            app_req_valid = 4'b0100;
            app_req_data[2*RW +: RW] = qd[p];
            app_req_mdata[2*MW +: MW] = qm[p];
            tick();
            chk("t3_blocked", fiu_req_valid, 0);
            if (p == 3) chk("t3_almfull_low", app_almFull, 0);
        end
        app_req_valid = '0;
        tick();
        chk("t3_almfull_high", app_almFull, 4'b0100);
        chk("t3_still_blocked", fiu_req_valid, 0);
        fiu_almFull = 1'b0;
        for (int p = 0; p < 5; p++) begin
            tick();
            chk("t3_drain_valid", fiu_req_valid, 1);
            chk("t3_drain_data", fiu_req_data, qd[p]);
            chk("t3_drain_mdata", fiu_req_mdata, {2'd2, qm[p][13:0]});
        end
        tick();
        chk("t3_drained", fiu_req_valid, 0);
        chk("t3_almfull_clear", app_almFull, 0);

        // Reset with queued and outstanding work
        fiu_almFull = 1'b1;
        app_req_valid = 4'b0010;
        repeat (3) tick();
        app_req_valid = '0;
        chk("t6_pre_not_empty", app_notEmpty, 4'b0110);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fiu_almFull = 1'b0;
        chk("t6_req_valid", fiu_req_valid, 0);
        chk("t6_req_mdata", fiu_req_mdata, 0);
        chk("t6_req_data", fiu_req_data, 0);
        chk("t6_not_empty", app_notEmpty, 0);
        chk("t6_almfull", app_almFull, 0);
        chk("t6_rsp_valid", app_rsp_valid, 0);
        repeat (6) begin
            tick();
            chk("t6_no_issue", fiu_req_valid, 0);
        end

        // Randomized traffic, then a bounded drain
        repeat (400) rnd_cycle(1'b1, 1'b1);
        for (int c = 0; c < 600; c++) begin
            pending = out_tags.size();
            for (int i = 0; i < N; i++) pending += mq[i].size();
            if (pending == 0 && app_notEmpty == '0) break;
            rnd_cycle(1'b0, 1'b0);
        end
        pending = out_tags.size();
        for (int i = 0; i < N; i++) pending += mq[i].size();
        chk("drain_model_empty", pending, 0);
        chk("drain_not_empty", app_notEmpty, 0);
        chk("drain_tag_err", tag_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
